// File: rtl/pc_sequencer.sv
// Fetch-stage control for the 5-stage RISC-V pipeline: drives programCounter en/PCMux,
// IF/ID and ID/EX flush/stall, tracks an in-flight imem fetch and keeps stall/redirect counters.
module pc_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    input  logic             imem_ready,
    input  logic             load_use_hazard,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic             ex_taken,
    input  logic             ex_jal,
    input  logic             ex_jalr,
    input  logic             ex_trap,
    input  logic             ex_ebreak,
    output logic             pc_en,
    output logic [1:0]       pc_mux,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             stall_ifid,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_BOOT    = 2'd0,
        S_FETCH   = 2'd1,
        S_DISCARD = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             outstanding_q, outstanding_d;
    logic             halt_pend_q, halt_pend_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;

    logic       redir;
    logic [1:0] redir_mux;
    logic       ebreak;
    logic       stall_inc;
    logic       redir_inc;

    assign ebreak    = ex_valid & ex_ebreak;
    assign redir     = ex_valid & (ex_trap | ex_jalr | ex_jal | (ex_branch & ex_taken));
    assign redir_mux = ex_trap ? 2'd3 : (ex_jalr ? 2'd2 : 2'd1);

    always_comb begin
        state_d     = state_q;
        halt_pend_d = halt_pend_q;
        imem_req    = 1'b0;
        pc_en       = 1'b0;
        pc_mux      = 2'd0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        stall_ifid  = 1'b0;
        halted      = 1'b0;
        stall_inc   = 1'b0;
        redir_inc   = 1'b0;

        case (state_q)
            S_BOOT: begin
                pc_en      = 1'b1;
                pc_mux     = 2'd3;
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
                state_d    = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (ebreak) begin
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    state_d    = S_HALT;
                end else if (redir) begin
                    pc_en      = 1'b1;
                    pc_mux     = redir_mux;
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    redir_inc  = 1'b1;
                    // The fetch still in flight was issued for the old PC.
                    if (!imem_ready) state_d = S_DISCARD;
                end else if (load_use_hazard) begin
                    stall_ifid = 1'b1;
                    flush_idex = 1'b1;
                    stall_inc  = 1'b1;
                end else if (imem_ready) begin
                    pc_en = 1'b1;
                end else begin
                    flush_ifid = 1'b1;
                    stall_inc  = 1'b1;
                end
            end
            S_DISCARD: begin
                imem_req   = 1'b1;
                flush_ifid = 1'b1;
                stall_inc  = 1'b1;
                if (ebreak) begin
                    flush_idex  = 1'b1;
                    halt_pend_d = 1'b1;
                end else if (redir) begin
                    pc_en      = 1'b1;
                    pc_mux     = redir_mux;
                    flush_idex = 1'b1;
                    redir_inc  = 1'b1;
                end
                if (imem_ready) begin
                    state_d     = (halt_pend_q || ebreak) ? S_HALT : S_FETCH;
                    halt_pend_d = 1'b0;
                end
            end
            default: begin
                halted     = 1'b1;
                flush_ifid = 1'b1;
                imem_req   = outstanding_q;
            end
        endcase

        // Reset forces a quiet, fully flushed front end and abandons any request.
        if (rst) begin
            imem_req   = 1'b0;
            pc_en      = 1'b0;
            pc_mux     = 2'd0;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            stall_ifid = 1'b0;
            halted     = 1'b0;
        end

        outstanding_d  = imem_ready ? 1'b0 : (imem_req | outstanding_q);
        stall_cnt_d    = (stall_inc && stall_cnt_q != CNT_MAX) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        redirect_cnt_d = (redir_inc && redirect_cnt_q != CNT_MAX) ? redirect_cnt_q + 1'b1
                                                                   : redirect_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_BOOT;
            outstanding_q  <= 1'b0;
            halt_pend_q    <= 1'b0;
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            outstanding_q  <= outstanding_d;
            halt_pend_q    <= halt_pend_d;
            stall_cnt_q    <= stall_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign redirect_cnt = redirect_cnt_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; a second CNT_W=2 instance shares the stimulus
// so counter saturation can be observed.
module tb_pc_sequencer;

    localparam logic [1:0] ST_BOOT = 2'd0, ST_FETCH = 2'd1, ST_DISCARD = 2'd2, ST_HALT = 2'd3;

    logic clk, rst;
    logic imem_ready, load_use_hazard;
    logic ex_valid, ex_branch, ex_taken, ex_jal, ex_jalr, ex_trap, ex_ebreak;

    logic        imem_req, pc_en, flush_ifid, flush_idex, stall_ifid, halted;
    logic [1:0]  pc_mux, state_dbg;
    logic [15:0] stall_cnt, redirect_cnt;

    logic        s_imem_req, s_pc_en, s_flush_ifid, s_flush_idex, s_stall_ifid, s_halted;
    logic [1:0]  s_pc_mux, s_state_dbg;
    logic [1:0]  s_stall_cnt, s_redirect_cnt;

    int checks = 0;
    int passes = 0;

    pc_sequencer #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ready(imem_ready),
        .load_use_hazard(load_use_hazard), .ex_valid(ex_valid), .ex_branch(ex_branch),
        .ex_taken(ex_taken), .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_trap(ex_trap),
        .ex_ebreak(ex_ebreak), .pc_en(pc_en), .pc_mux(pc_mux), .flush_ifid(flush_ifid),
        .flush_idex(flush_idex), .stall_ifid(stall_ifid), .halted(halted),
        .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt), .state_dbg(state_dbg)
    );

    pc_sequencer #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .imem_req(s_imem_req), .imem_ready(imem_ready),
        .load_use_hazard(load_use_hazard), .ex_valid(ex_valid), .ex_branch(ex_branch),
        .ex_taken(ex_taken), .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_trap(ex_trap),
        .ex_ebreak(ex_ebreak), .pc_en(s_pc_en), .pc_mux(s_pc_mux), .flush_ifid(s_flush_ifid),
        .flush_idex(s_flush_idex), .stall_ifid(s_stall_ifid), .halted(s_halted),
        .stall_cnt(s_stall_cnt), .redirect_cnt(s_redirect_cnt), .state_dbg(s_state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        load_use_hazard = 1'b0;
        ex_valid = 1'b0; ex_branch = 1'b0; ex_taken = 1'b0;
        ex_jal = 1'b0; ex_jalr = 1'b0; ex_trap = 1'b0; ex_ebreak = 1'b0;
    endtask

    // Leaves the DUT at the start of its first FETCH cycle.
    task automatic do_reset();
        clear_ex();
        imem_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        clear_ex();
        imem_ready = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (pc_en !== 1'b0) $display("FAIL rst_pc_en: got %0b expected 0", pc_en); else passes++;
            checks++; if ({flush_ifid, flush_idex} !== 2'b11) $display("FAIL rst_flush: got %b expected 11", {flush_ifid, flush_idex}); else passes++;
            checks++; if ({imem_req, stall_ifid, halted, pc_mux} !== 5'b0) $display("FAIL rst_quiet: got %b expected 00000", {imem_req, stall_ifid, halted, pc_mux}); else passes++;
            tick();
        end
        checks++; if (stall_cnt !== 16'd0 || redirect_cnt !== 16'd0) $display("FAIL rst_counters: got %0d/%0d expected 0/0", stall_cnt, redirect_cnt); else passes++;
        checks++; if (state_dbg !== ST_BOOT) $display("FAIL rst_state: got %0d expected %0d", state_dbg, ST_BOOT); else passes++;
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({pc_en, pc_mux, imem_req} !== 4'b1110) $display("FAIL boot_cycle: got en,mux,req=%b expected 1110", {pc_en, pc_mux, imem_req}); else passes++;
        checks++; if ({flush_ifid, flush_idex} !== 2'b11) $display("FAIL boot_flush: got %b expected 11", {flush_ifid, flush_idex}); else passes++;
        tick();
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) $display("FAIL boot_req_rise: got %0b expected 1", imem_req); else passes++;
        checks++; if (state_dbg !== ST_FETCH) $display("FAIL boot_to_fetch: got %0d expected %0d", state_dbg, ST_FETCH); else passes++;
        tick();
    endtask

    task automatic test_streaming();
        do_reset();
        imem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if ({pc_en, pc_mux, flush_ifid, flush_idex} !== 5'b10000) $display("FAIL stream_cycle%0d: got en,mux,fl=%b expected 10000", i, {pc_en, pc_mux, flush_ifid, flush_idex}); else passes++;
            tick();
        end
        checks++; if (stall_cnt !== 16'd0 || redirect_cnt !== 16'd0) $display("FAIL stream_counters: got %0d/%0d expected 0/0", stall_cnt, redirect_cnt); else passes++;
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if ({pc_en, flush_ifid, imem_req} !== 3'b011) $display("FAIL wait_cycle%0d: got en,flush_ifid,req=%b expected 011", i, {pc_en, flush_ifid, imem_req}); else passes++;
            tick();
        end
        imem_ready = 1'b1;
        @(negedge clk);
        checks++; if (stall_cnt !== 16'd2) $display("FAIL wait_stall_cnt: got %0d expected 2", stall_cnt); else passes++;
        tick();
    endtask

    task automatic test_redirect_priority();
        do_reset();
        imem_ready = 1'b1;
        ex_valid = 1'b1; ex_branch = 1'b1; ex_taken = 1'b1;
        @(negedge clk);
        checks++; if ({pc_en, pc_mux, flush_ifid, flush_idex} !== 5'b10111) $display("FAIL taken_branch: got en,mux,fl=%b expected 10111", {pc_en, pc_mux, flush_ifid, flush_idex}); else passes++;
        tick();
        ex_taken = 1'b0;
        @(negedge clk);
        checks++; if (redirect_cnt !== 16'd1) $display("FAIL taken_redirect_cnt: got %0d expected 1", redirect_cnt); else passes++;
        checks++; if ({pc_en, pc_mux, flush_ifid, flush_idex} !== 5'b10000) $display("FAIL not_taken: got en,mux,fl=%b expected 10000", {pc_en, pc_mux, flush_ifid, flush_idex}); else passes++;
        tick();
        ex_branch = 1'b0; ex_jalr = 1'b1;
        @(negedge clk);
        checks++; if (pc_mux !== 2'd2) $display("FAIL jalr_mux: got %0d expected 2", pc_mux); else passes++;
        tick();
        ex_trap = 1'b1;
        @(negedge clk);
        checks++; if (pc_mux !== 2'd3) $display("FAIL jalr_trap_mux: got %0d expected 3", pc_mux); else passes++;
        tick();
        clear_ex();
        @(negedge clk);
        checks++; if (redirect_cnt !== 16'd3) $display("FAIL priority_redirect_cnt: got %0d expected 3", redirect_cnt); else passes++;
        checks++; if (state_dbg !== ST_FETCH) $display("FAIL priority_state: got %0d expected %0d", state_dbg, ST_FETCH); else passes++;
        tick();
    endtask

    task automatic test_redirect_wait();
        do_reset();
        imem_ready = 1'b0;
        ex_valid = 1'b1; ex_branch = 1'b1; ex_taken = 1'b1;
        @(negedge clk);
        checks++; if ({pc_en, pc_mux} !== 3'b101) $display("FAIL wait_redirect: got en,mux=%b expected 101", {pc_en, pc_mux}); else passes++;
        tick();
        clear_ex();
        for (int i = 0; i < 3; i++) begin
            imem_ready = (i == 2);
            @(negedge clk);
            checks++; if (state_dbg !== ST_DISCARD) $display("FAIL discard_state%0d: got %0d expected %0d", i, state_dbg, ST_DISCARD); else passes++;
            checks++; if ({pc_en, flush_ifid, imem_req} !== 3'b011) $display("FAIL discard_out%0d: got en,flush_ifid,req=%b expected 011", i, {pc_en, flush_ifid, imem_req}); else passes++;
            tick();
        end
        imem_ready = 1'b1;
        @(negedge clk);
        checks++; if ({pc_en, pc_mux, flush_ifid} !== 4'b1000) $display("FAIL resume_fetch: got en,mux,flush_ifid=%b expected 1000", {pc_en, pc_mux, flush_ifid}); else passes++;
        checks++; if (stall_cnt !== 16'd3 || redirect_cnt !== 16'd1) $display("FAIL discard_counters: got %0d/%0d expected 3/1", stall_cnt, redirect_cnt); else passes++;
        tick();
    endtask

    task automatic test_hazard();
        do_reset();
        imem_ready = 1'b1;
        load_use_hazard = 1'b1;
        @(negedge clk);
        checks++; if ({pc_en, stall_ifid, flush_idex, flush_ifid} !== 4'b0110) $display("FAIL hazard: got en,stall,fl_idex,fl_ifid=%b expected 0110", {pc_en, stall_ifid, flush_idex, flush_ifid}); else passes++;
        tick();
        ex_valid = 1'b1; ex_jal = 1'b1;
        @(negedge clk);
        checks++; if ({pc_en, pc_mux, stall_ifid, flush_ifid} !== 5'b10101) $display("FAIL hazard_jal: got en,mux,stall,fl_ifid=%b expected 10101", {pc_en, pc_mux, stall_ifid, flush_ifid}); else passes++;
        tick();
        clear_ex();
        @(negedge clk);
        checks++; if (stall_cnt !== 16'd1 || redirect_cnt !== 16'd1) $display("FAIL hazard_counters: got %0d/%0d expected 1/1", stall_cnt, redirect_cnt); else passes++;
        tick();
    endtask

    task automatic test_halt();
        do_reset();
        imem_ready = 1'b0;
        ex_valid = 1'b1; ex_ebreak = 1'b1;
        @(negedge clk);
        checks++; if ({imem_req, pc_en, flush_ifid, flush_idex, halted} !== 5'b10110) $display("FAIL ebreak: got req,en,fl,fl,halted=%b expected 10110", {imem_req, pc_en, flush_ifid, flush_idex, halted}); else passes++;
        tick();
        clear_ex();
        @(negedge clk);
        checks++; if ({halted, imem_req, pc_en} !== 3'b110) $display("FAIL halt_outstanding: got halted,req,en=%b expected 110", {halted, imem_req, pc_en}); else passes++;
        tick();
        imem_ready = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) $display("FAIL halt_req_until_ready: got %0b expected 1", imem_req); else passes++;
        tick();
        imem_ready = 1'b0;
        @(negedge clk);
        checks++; if ({halted, imem_req} !== 2'b10) $display("FAIL halt_req_drop: got halted,req=%b expected 10", {halted, imem_req}); else passes++;
        tick();
        imem_ready = 1'b1;
        ex_valid = 1'b1; ex_branch = 1'b1; ex_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({halted, pc_en, flush_ifid} !== 3'b101) $display("FAIL halt_sticky%0d: got halted,en,fl=%b expected 101", i, {halted, pc_en, flush_ifid}); else passes++;
            tick();
        end
        clear_ex();
        @(negedge clk);
        checks++; if (redirect_cnt !== 16'd0 || state_dbg !== ST_HALT) $display("FAIL halt_ignores: got cnt=%0d state=%0d expected 0/3", redirect_cnt, state_dbg); else passes++;

        // EBREAK arriving while a stale fetch is being discarded
        do_reset();
        imem_ready = 1'b0;
        ex_valid = 1'b1; ex_branch = 1'b1; ex_taken = 1'b1;
        tick();
        ex_branch = 1'b0; ex_taken = 1'b0; ex_ebreak = 1'b1;
        @(negedge clk);
        checks++; if ({state_dbg, pc_en} !== {ST_DISCARD, 1'b0}) $display("FAIL discard_ebreak: got state,en=%b expected 100", {state_dbg, pc_en}); else passes++;
        tick();
        clear_ex();
        imem_ready = 1'b1;
        @(negedge clk);
        checks++; if ({state_dbg, halted} !== {ST_DISCARD, 1'b0}) $display("FAIL discard_pending: got state,halted=%b expected 100", {state_dbg, halted}); else passes++;
        tick();
        imem_ready = 1'b0;
        @(negedge clk);
        checks++; if ({state_dbg, halted, imem_req} !== {ST_HALT, 2'b10}) $display("FAIL discard_to_halt: got state,halted,req=%b expected 1110", {state_dbg, halted, imem_req}); else passes++;
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        imem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ex_valid = 1'b1; ex_branch = 1'b1; ex_taken = 1'b1;
            tick();
        end
        clear_ex();
        imem_ready = 1'b0;
        @(negedge clk);
        checks++; if (redirect_cnt !== 16'd5) $display("FAIL redirect_cnt_w16: got %0d expected 5", redirect_cnt); else passes++;
        checks++; if (s_redirect_cnt !== 2'd3) $display("FAIL redirect_cnt_sat: got %0d expected 3", s_redirect_cnt); else passes++;
        for (int i = 0; i < 4; i++) tick();
        @(negedge clk);
        checks++; if (stall_cnt !== 16'd4) $display("FAIL stall_cnt_w16: got %0d expected 4", stall_cnt); else passes++;
        checks++; if (s_stall_cnt !== 2'd3) $display("FAIL stall_cnt_sat: got %0d expected 3", s_stall_cnt); else passes++;
        tick();
    endtask

    // Final report
    initial begin
        clear_ex();
        imem_ready = 1'b0;
        test_reset();
        test_streaming();
        test_redirect_priority();
        test_redirect_wait();
        test_hazard();
        test_halt();
        test_saturation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Control block for the fetch stage of the 5-stage RISC-V pipeline. It drives `programCounter`'s `en` and `PCMux` inputs each cycle from instruction-memory handshake status, decode-stage load-use hazards and execute-stage control-flow resolution. It also generates IF/ID and ID/EX flush/stall controls, tracks an outstanding fetch across redirects, and keeps saturating stall and redirect counters.

## Interface
- `CNT_W`, 16: width of each performance counter.

- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `imem_req`  out  1  fetch request; address is `PCOut`, sampled by imem on the first cycle of each request.
- `imem_ready`  in  1  fetch data valid this cycle; completes the outstanding request.
- `load_use_hazard`  in  1  decode instruction needs the result of a load in EX.
- `ex_valid`  in  1  EX stage holds a valid instruction.
- `ex_branch`, `ex_taken`  in  1  conditional branch in EX; condition true.
- `ex_jal`, `ex_jalr`  in  1  JAL / JALR in EX.
- `ex_trap`  in  1  ECALL or illegal instruction in EX.
- `ex_ebreak`  in  1  EBREAK in EX.
- `pc_en`  out  1  to `programCounter.en`.
- `pc_mux`  out  2  to `programCounter.PCMux`: 0 = PC+4, 1 = PC_Execute+Imm, 2 = Reg1+Imm (JALR), 3 = boot/trap vector.
- `flush_ifid`, `flush_idex`  out  1  insert a bubble into that pipeline register.
- `stall_ifid`  out  1  hold the IF/ID register.
- `halted`  out  1  core is halted.
- `stall_cnt`, `redirect_cnt`  out  CNT_W  saturating counters.

## Operation
- States: BOOT, FETCH, DISCARD, HALT. An `outstanding` flag is set on any cycle with `imem_req=1` and `imem_ready=0`, and cleared on `imem_ready`.
- Outputs are combinational from state and inputs. Unlisted outputs are 0.
- BOOT: `pc_en=1`, `pc_mux=3`, `flush_ifid=flush_idex=1`, `imem_req=0`. Next state is FETCH.
- FETCH: `imem_req=1`. The first matching case applies:
  1. `ex_valid&ex_ebreak`: `pc_en=0`, both flushes = 1. Next state is HALT.
  2. `ex_valid&ex_trap`: redirect with `pc_mux=3`.
  3. `ex_valid&ex_jalr`: redirect with `pc_mux=2`.
  4. `ex_valid&(ex_jal|(ex_branch&ex_taken))`: redirect with `pc_mux=1`.
  5. `load_use_hazard`: `pc_en=0`, `stall_ifid=1`, `flush_idex=1`. Any fetched word is dropped and the same PC is refetched.
  6. `imem_ready`: `pc_en=1`, `pc_mux=0`.
  7. Otherwise (memory wait): `pc_en=0`, `flush_ifid=1`.
- Redirect: `pc_en=1`, both flushes = 1, `redirect_cnt` increments. If `imem_ready=0`, the fetch in flight targets the old PC, so the next state is DISCARD. Otherwise the state stays FETCH.
- DISCARD: `imem_req=1`, `pc_en=0`, `flush_ifid=1`. Stays until `imem_ready`, then goes to FETCH; the returned data is dropped. A redirect in DISCARD (trap/jalr/jal/branch, same priority) updates the PC and stays in DISCARD. `ex_ebreak` in DISCARD sets `halted` on exit; the state goes to HALT instead of FETCH.
- HALT: `halted=1`, `pc_en=0`, `flush_ifid=1`. `imem_req` stays 1 only while `outstanding`. Only `rst` exits HALT.
- `stall_cnt` increments in FETCH cases 5 and 7 and on every DISCARD cycle.
- Both counters saturate at 2^CNT_W−1 and never wrap.
- `stall_ifid` and `flush_ifid` are never both 1.

## Timing
- While `rst=1`: state is BOOT, `pc_en=0`, `pc_mux=0`, `imem_req=0`, `flush_ifid=flush_idex=1`, `stall_ifid=0`, `halted=0`, counters 0, `outstanding=0`.
- Reset asserted mid-request drops the request. imem must tolerate the request being abandoned.
- First cycle after reset release is BOOT. `PCOut` holds the vector after that edge, and `imem_req` first rises the cycle after.
- Redirect latency: redirect decoded in cycle N → `PCOut` holds the target after the edge ending cycle N. Penalty is 2 bubbles (IF/ID, ID/EX), plus the DISCARD cycles if a fetch was in flight.
- Fetch throughput: with `imem_ready` tied high, one PC+4 advance per cycle.
- Handshake: once raised, `imem_req` stays high until `imem_ready`. In FETCH it stays high continuously, so a new request starts the cycle after each completion.

## Test plan
- Reset boot: hold `rst` for 3 cycles → `pc_en=0` and both flushes = 1. Release → 1 cycle with `pc_en=1`, `pc_mux=3`, `imem_req=0`, then `imem_req=1`.
- Streaming: `imem_ready=1` for 10 cycles with no events → `pc_en=1`, `pc_mux=0` every cycle; counters stay 0. Then `imem_ready=0` for 2 cycles → `pc_en=0`, `flush_ifid=1`, `stall_cnt=2`.
- Redirect priority, each with `imem_ready=1`:
  - taken branch → `pc_mux=1`, both flushes, `redirect_cnt=1`;
  - not-taken branch → `pc_mux=0`, no flush;
  - JALR → `pc_mux=2`;
  - JALR+trap in the same cycle → `pc_mux=3`.
- Redirect during wait: taken branch with `imem_ready=0` → `pc_en=1`, `pc_mux=1`, next state DISCARD. `imem_ready` arrives 3 cycles later → `flush_ifid=1` and `pc_en=0` that cycle, then normal fetch resumes; `stall_cnt` +3.
- Hazard: `load_use_hazard` for 1 cycle with `imem_ready=1` → `pc_en=0`, `stall_ifid=1`, `flush_idex=1`, `flush_ifid=0`. Hazard plus JAL in the same cycle → redirect wins, `stall_ifid=0`.
- Halt and saturation:
  - EBREAK with a fetch outstanding → `imem_req` stays 1 until `imem_ready`, then 0; `halted=1` persists until `rst`.
  - With `CNT_W=2`, 5 redirects → `redirect_cnt=3`.
